// File: rtl/ddr2_mem_scoreboard.sv
// Shadow-memory data checker for the DDR2 model debug stream: mirrors write bursts, checks read beats.
// Check result registered one cycle after rd_valid; no backpressure, bursts arriving while busy are dropped.
// Optional read-burst structure tracking enabled by DDR2_SB_BURST_CHECK_EN.
module ddr2_mem_scoreboard #(
   parameter int DEPTH     = 1024,
   parameter int BURST_LEN = 8,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_valid,
   input  logic [31:0]      wr_addr,
   input  logic [15:0]      wr_data,
   input  logic             rd_valid,
   input  logic [31:0]      rd_addr,
   input  logic [15:0]      rd_data,
   output logic             chk_valid,
   output logic             chk_pass,
   output logic [CNT_W-1:0] chk_count,
   output logic [CNT_W-1:0] mismatch_count,
   output logic [CNT_W-1:0] uninit_count,
   output logic [31:0]      first_err_addr,
   output logic [15:0]      first_err_exp,
   output logic [15:0]      first_err_got,
   output logic             overflow_err,
   output logic             burst_err
);

   localparam int IW = $clog2(DEPTH);
   localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [BW-1:0]    LAST_BEAT = BW'(BURST_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   typedef enum logic {IDLE, EXPAND} state_t;

   state_t           state_q, state_d;
   logic [BW-1:0]    beat_q, beat_d;
   logic [31:0]      base_q;
   logic [15:0]      data_q;
   logic             load, wr_en, ovf_set;
   logic [15:0]      mem [DEPTH];
   logic [DEPTH-1:0] valid_q;
   logic [IW-1:0]    wr_idx, rd_idx, rd_off;
   logic             fwd, rd_init, rd_miss;
   logic [15:0]      rd_exp;

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      load    = 1'b0;
      wr_en   = 1'b0;
      ovf_set = 1'b0;
      case (state_q)
         IDLE: begin
            if (wr_valid) begin
               load    = 1'b1;
               beat_d  = '0;
               state_d = EXPAND;
            end
         end
         EXPAND: begin
            wr_en   = 1'b1;
            ovf_set = wr_valid;
            if (beat_q == LAST_BEAT) begin
               beat_d  = '0;
               state_d = IDLE;
            end else begin
               beat_d = beat_q + BW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         beat_q  <= '0;
         base_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         if (load) begin
            base_q <= wr_addr;
            data_q <= wr_data;
         end
      end
   end

   assign wr_idx = IW'(base_q + 32'(beat_q));

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_idx] <= data_q;
   end

   always_ff @(posedge clk) begin
      if (reset)      valid_q <= '0;
      else if (wr_en) valid_q[wr_idx] <= 1'b1;
   end

   // The model commits a whole burst at once, so beats not yet expanded are served from data_q.
   assign rd_idx  = rd_addr[IW-1:0];
   assign rd_off  = IW'(rd_addr - base_q);
   assign fwd     = (state_q == EXPAND) && (rd_off >= IW'(beat_q)) && (rd_off <= IW'(BURST_LEN - 1));
   assign rd_init = fwd | valid_q[rd_idx];
   assign rd_exp  = fwd ? data_q : (valid_q[rd_idx] ? mem[rd_idx] : 16'h0000);
   assign rd_miss = (rd_data != rd_exp);

   always_ff @(posedge clk) begin
      if (reset) begin
         chk_valid      <= 1'b0;
         chk_pass       <= 1'b0;
         chk_count      <= '0;
         mismatch_count <= '0;
         uninit_count   <= '0;
         first_err_addr <= '0;
         first_err_exp  <= '0;
         first_err_got  <= '0;
         overflow_err   <= 1'b0;
      end else begin
         chk_valid <= rd_valid;
         chk_pass  <= rd_valid & ~rd_miss;
         if (ovf_set) overflow_err <= 1'b1;
         if (rd_valid) begin
            if (chk_count != CNT_MAX) chk_count <= chk_count + CNT_W'(1);
            if (!rd_init && uninit_count != CNT_MAX) uninit_count <= uninit_count + CNT_W'(1);
            if (rd_miss) begin
               if (mismatch_count != CNT_MAX) mismatch_count <= mismatch_count + CNT_W'(1);
               if (mismatch_count == '0) begin
                  first_err_addr <= rd_addr;
                  first_err_exp  <= rd_exp;
                  first_err_got  <= rd_data;
               end
            end
         end
      end
   end

`ifdef DDR2_SB_BURST_CHECK_EN
   logic          bt_act;
   logic [BW-1:0] bt_beat;
   logic [31:0]   bt_prev;
   logic          bt_bad;

   // Column address increments within its low 5 bits; any break restarts the tracker at this beat.
   assign bt_bad = bt_act && (rd_addr != {bt_prev[31:5], 5'(bt_prev[4:0] + 5'd1)});

   always_ff @(posedge clk) begin
      if (reset) begin
         bt_act    <= 1'b0;
         bt_beat   <= '0;
         bt_prev   <= '0;
         burst_err <= 1'b0;
      end else if (rd_valid) begin
         bt_prev <= rd_addr;
         if (bt_bad) burst_err <= 1'b1;
         if (!bt_act || bt_bad) begin
            bt_act  <= (BURST_LEN > 1);
            bt_beat <= BW'(1);
         end else if (bt_beat == LAST_BEAT) begin
            bt_act  <= 1'b0;
            bt_beat <= '0;
         end else begin
            bt_beat <= bt_beat + BW'(1);
         end
      end else if (bt_act) begin
         burst_err <= 1'b1;
         bt_act    <= 1'b0;
         bt_beat   <= '0;
      end
   end
`else
   assign burst_err = 1'b0;
`endif

endmodule

// File: tb/tb_ddr2_mem_scoreboard.sv
// Directed and randomized checks of ddr2_mem_scoreboard against a commit-at-once memory model.
module tb_ddr2_mem_scoreboard;
   localparam int DEPTH = 1024;
   localparam int BL    = 8;
   localparam int CW    = 6;
   localparam int CMAX  = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset, wr_valid, rd_valid;
   logic [31:0]   wr_addr, rd_addr;
   logic [15:0]   wr_data, rd_data;
   logic          chk_valid, chk_pass, overflow_err, burst_err;
   logic [CW-1:0] chk_count, mismatch_count, uninit_count;
   logic [31:0]   first_err_addr;
   logic [15:0]   first_err_exp, first_err_got;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: a write burst lands in full at the edge it is accepted.
   logic [15:0] m_val [DEPTH];
   bit          m_init [DEPTH];
   int          m_chk, m_mm, m_un, m_busy;
   logic [31:0] m_fa;
   logic [15:0] m_fe, m_fg;
   bit          m_ovf, m_cv, m_cp;

   ddr2_mem_scoreboard #(.DEPTH(DEPTH), .BURST_LEN(BL), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset),
      .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_data(rd_data),
      .chk_valid(chk_valid), .chk_pass(chk_pass),
      .chk_count(chk_count), .mismatch_count(mismatch_count), .uninit_count(uninit_count),
      .first_err_addr(first_err_addr), .first_err_exp(first_err_exp), .first_err_got(first_err_got),
      .overflow_err(overflow_err), .burst_err(burst_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] m_exp(input logic [31:0] a);
      int idx = int'(a % DEPTH);
      return m_init[idx] ? m_val[idx] : 16'h0000;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) m_init[i] = 0;
      m_chk = 0; m_mm = 0; m_un = 0; m_busy = 0;
      m_fa = '0; m_fe = '0; m_fg = '0;
      m_ovf = 0; m_cv = 0; m_cp = 0;
   endtask

   task automatic model_edge();
      logic [15:0] e;
      m_cv = rd_valid;
      m_cp = 0;
      if (rd_valid) begin
         e = m_exp(rd_addr);
         m_cp = (rd_data == e);
         if (m_chk < CMAX) m_chk++;
         if (!m_init[int'(rd_addr % DEPTH)] && m_un < CMAX) m_un++;
         if (!m_cp) begin
            if (m_mm == 0) begin
               m_fa = rd_addr; m_fe = e; m_fg = rd_data;
            end
            if (m_mm < CMAX) m_mm++;
         end
      end
      if (m_busy > 0) begin
         m_busy--;
         if (wr_valid) m_ovf = 1;
      end else if (wr_valid) begin
         for (int b = 0; b < BL; b++) begin
            m_val[int'((wr_addr + b) % DEPTH)]  = wr_data;
            m_init[int'((wr_addr + b) % DEPTH)] = 1;
         end
         m_busy = BL;
      end
   endtask

   task automatic check_all(input bit check_burst);
      chk("chk_valid", {31'd0, chk_valid}, {31'd0, m_cv});
      if (m_cv) chk("chk_pass", {31'd0, chk_pass}, {31'd0, m_cp});
      chk("chk_count", 32'(chk_count), 32'(m_chk));
      chk("mismatch_count", 32'(mismatch_count), 32'(m_mm));
      chk("uninit_count", 32'(uninit_count), 32'(m_un));
      chk("first_err_addr", first_err_addr, m_fa);
      chk("first_err_exp", 32'(first_err_exp), 32'(m_fe));
      chk("first_err_got", 32'(first_err_got), 32'(m_fg));
      chk("overflow_err", {31'd0, overflow_err}, {31'd0, m_ovf});
      if (check_burst) chk("burst_err_idle", {31'd0, burst_err}, 32'd0);
   endtask

   task automatic step(input bit wv, input logic [31:0] wa, input logic [15:0] wd,
                       input bit rv, input logic [31:0] ra, input logic [15:0] rd);
      bit cb;
      @(negedge clk);
      wr_valid = wv; wr_addr = wa; wr_data = wd;
      rd_valid = rv; rd_addr = ra; rd_data = rd;
      @(posedge clk);
      model_edge();
      #1;
`ifdef DDR2_SB_BURST_CHECK_EN
      cb = 0;
`else
      cb = 1;
`endif
      check_all(cb);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 32'd0, 16'd0, 0, 32'd0, 16'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
      rd_valid = 1'b0; rd_addr = '0; rd_data = '0;
      @(posedge clk);
      model_clear();
      #1;
      reset = 1'b0;
      check_all(1'b1);
   endtask

   function automatic logic [31:0] pick_addr();
      case ($urandom_range(0, 3))
         0:       return 32'($urandom_range(1012, 1023));
         1:       return 32'hFFFF_0000 + 32'($urandom_range(0, 40));
         default: return 32'($urandom_range(0, 48));
      endcase
   endfunction

   initial begin
      logic [31:0] ra;
      bit          wv, rv;

      // 1: uninitialised read of zero passes
      do_reset();
      step(0, 0, 0, 1, 32'd5, 16'h0000);
      chk("t1_pass", {31'd0, chk_pass}, 32'd1);
      chk("t1_uninit", 32'(uninit_count), 32'd1);
      chk("t1_mismatch", 32'(mismatch_count), 32'd0);

      // 2: burst at 32 then read back
      do_reset();
      step(1, 32'd32, 16'hA5A5, 0, 0, 0);
      idle(8);
      for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 32'd32 + 32'(i), 16'hA5A5);
      chk("t2_count", 32'(chk_count), 32'd8);
      chk("t2_mismatch", 32'(mismatch_count), 32'd0);

      // 3: burst wraps the shadow index
      do_reset();
      step(1, 32'd1020, 16'h1234, 0, 0, 0);
      idle(8);
      for (int i = 0; i < 8; i++) step(0, 0, 0, 1, (32'd1020 + 32'(i)) % 1024, 16'h1234);
      chk("t3_mismatch", 32'(mismatch_count), 32'd0);
      chk("t3_uninit", 32'(uninit_count), 32'd0);

      // 4: forwarding during expansion and first-mismatch capture
      do_reset();
      step(1, 32'd64, 16'hBEEF, 0, 0, 0);
      step(0, 0, 0, 1, 32'd67, 16'hBEEF);
      chk("t4_fwd_pass", {31'd0, chk_pass}, 32'd1);
      step(0, 0, 0, 1, 32'd66, 16'hDEAD);
      chk("t4_fail", {31'd0, chk_pass}, 32'd0);
      chk("t4_fa", first_err_addr, 32'd66);
      chk("t4_fe", 32'(first_err_exp), 32'h0000_BEEF);
      chk("t4_fg", 32'(first_err_got), 32'h0000_DEAD);
      step(0, 0, 0, 1, 32'd65, 16'h0BAD);
      chk("t4_frozen", 32'(first_err_got), 32'h0000_DEAD);

      // 5: second burst while busy is dropped
      do_reset();
      step(1, 32'd200, 16'h1111, 0, 0, 0);
      idle(2);
      step(1, 32'd300, 16'h2222, 0, 0, 0);
      chk("t5_ovf", {31'd0, overflow_err}, 32'd1);
      idle(8);
      step(0, 0, 0, 1, 32'd300, 16'h0000);
      chk("t5_uninit", 32'(uninit_count), 32'd1);
      step(0, 0, 0, 1, 32'd207, 16'h1111);
      chk("t5_first_pass", {31'd0, chk_pass}, 32'd1);

      // simultaneous write and read: read sees pre-burst state
      do_reset();
      step(1, 32'd400, 16'h7777, 1, 32'd400, 16'h0000);
      chk("sim_pass", {31'd0, chk_pass}, 32'd1);
      chk("sim_uninit", 32'(uninit_count), 32'd1);

      // 6: read burst structure
      do_reset();
      for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 32'd96 + 32'(i), 16'h0000);
      idle(1);
      chk("t6_clean", {31'd0, burst_err}, 32'd0);
      do_reset();
      for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 32'd96 + 32'(i), 16'h0000);
      idle(1);
      step(0, 0, 0, 1, 32'd100, 16'h0000);
`ifdef DDR2_SB_BURST_CHECK_EN
      chk("t6_gap", {31'd0, burst_err}, 32'd1);
`else
      chk("t6_gap", {31'd0, burst_err}, 32'd0);
`endif

      // reset during expansion abandons the burst
      do_reset();
      step(1, 32'd500, 16'hABCD, 0, 0, 0);
      idle(3);
      do_reset();
      chk("rst_burst", {31'd0, burst_err}, 32'd0);
      idle(8);
      step(0, 0, 0, 1, 32'd500, 16'h0000);
      step(0, 0, 0, 1, 32'd505, 16'h0000);
      chk("rst_abandon", 32'(mismatch_count), 32'd0);

      // randomized traffic, also drives counters into saturation
      do_reset();
      for (int n = 0; n < 600; n++) begin
         wv = ($urandom_range(0, 5) == 0);
         rv = ($urandom_range(0, 2) != 0);
         ra = pick_addr();
         step(wv, pick_addr(), 16'($urandom), rv, ra,
              ($urandom_range(0, 1) == 1) ? m_exp(ra) : 16'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
